// File: rtl/code_nco_ctx_sched.sv
// Context scheduler that time-multiplexes one code NCO across CH_NUM channels.
// Each round: for every enabled channel read context, load the NCO, run blk_len strobes, write back.
module code_nco_ctx_sched #(
  parameter int unsigned CH_NUM = 32,
  parameter int unsigned CH_W   = 5
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              round_start,
  input  logic              round_abort,
  input  logic [CH_NUM-1:0] ch_enable,
  input  logic [7:0]        blk_len,
  output logic              ctx_rd_en,
  output logic              ctx_wr_en,
  output logic [CH_W-1:0]   ctx_addr,
  input  logic [71:0]       ctx_rd_data,
  output logic [39:0]       ctx_wr_data,
  output logic [31:0]       nco_code_freq,
  output logic              nco_phase_en,
  output logic [31:0]       nco_phase_ld,
  output logic              nco_jump_en,
  output logic [7:0]        nco_jump_ld,
  output logic              nco_fill_finished,
  output logic              nco_data_down_en,
  input  logic [31:0]       nco_phase_cur,
  input  logic [7:0]        nco_jump_cur,
  output logic [CH_W-1:0]   cur_ch,
  output logic              busy,
  output logic              round_done,
  output logic              round_overrun
);

  localparam int unsigned LEN_W = 8;
  localparam int unsigned ST_W  = 3;

  localparam logic [ST_W-1:0] S_IDLE = 3'd0;
  localparam logic [ST_W-1:0] S_SCAN = 3'd1;
  localparam logic [ST_W-1:0] S_RD   = 3'd2;
  localparam logic [ST_W-1:0] S_LD   = 3'd3;
  localparam logic [ST_W-1:0] S_FILL = 3'd4;
  localparam logic [ST_W-1:0] S_RUN  = 3'd5;
  localparam logic [ST_W-1:0] S_SAVE = 3'd6;

  logic [ST_W-1:0]   r_state;
  logic [CH_NUM-1:0] r_pending;
  logic [LEN_W-1:0]  r_blk_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [CH_W-1:0]   r_cur_ch;

  logic              r_ctx_rd_en;
  logic              r_ctx_wr_en;
  logic [CH_W-1:0]   r_ctx_addr;
  logic [31:0]       r_nco_code_freq;
  logic              r_nco_ld;
  logic              r_nco_fill;
  logic              r_nco_down;
  logic              r_busy;
  logic              r_round_done;
  logic              r_round_overrun;

  logic [ST_W-1:0]   w_state_nxt;
  logic [CH_NUM-1:0] w_pending_nxt;
  logic [LEN_W-1:0]  w_blk_len_nxt;
  logic [LEN_W-1:0]  w_cnt_nxt;
  logic [CH_W-1:0]   w_cur_ch_nxt;
  logic              w_any;
  logic [CH_W-1:0]   w_low_idx;
  logic              w_done_nxt;
  logic              w_overrun_nxt;

  // Lowest pending channel; descending scan so the last hit is the lowest index.
  always_comb begin
    w_any     = 1'b0;
    w_low_idx = '0;
    for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_any     = 1'b1;
        w_low_idx = CH_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_blk_len <= '0;
      r_cnt     <= '0;
      r_cur_ch  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_blk_len <= w_blk_len_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cur_ch  <= w_cur_ch_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_blk_len_nxt = r_blk_len;
    w_cnt_nxt     = r_cnt;
    w_cur_ch_nxt  = r_cur_ch;
    case (r_state)
      S_IDLE: begin
        if (round_start && !round_abort) begin
          w_state_nxt   = S_SCAN;
          w_pending_nxt = ch_enable;
          w_blk_len_nxt = blk_len;
          w_cur_ch_nxt  = '0;
        end
      end
      S_SCAN: begin
        if (w_any) begin
          w_cur_ch_nxt             = w_low_idx;
          w_pending_nxt[w_low_idx] = 1'b0;
          w_state_nxt              = S_RD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD:   w_state_nxt = S_LD;
      S_LD:   w_state_nxt = S_FILL;
      S_FILL: begin
        if (r_blk_len == '0) begin
          w_state_nxt = S_SAVE;
        end else begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = r_blk_len;
        end
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt - LEN_W'(1);
        if (r_cnt <= LEN_W'(1)) begin
          w_state_nxt = S_SAVE;
        end
      end
      S_SAVE:  w_state_nxt = S_SCAN;
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort overrides everything outside IDLE; the SAVE cycle's write is already on the bus.
    if (round_abort && (r_state != S_IDLE)) begin
      w_state_nxt   = S_IDLE;
      w_pending_nxt = '0;
    end
  end

  assign w_done_nxt    = (w_state_nxt == S_SCAN) && (w_pending_nxt == '0);
  assign w_overrun_nxt = round_start && !round_abort && (r_state != S_IDLE);

  // Strobes registered from the next state so they line up with their state cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_ctx_rd_en     <= 1'b0;
      r_ctx_wr_en     <= 1'b0;
      r_ctx_addr      <= '0;
      r_nco_ld        <= 1'b0;
      r_nco_fill      <= 1'b0;
      r_nco_down      <= 1'b0;
      r_busy          <= 1'b0;
      r_round_done    <= 1'b0;
      r_round_overrun <= 1'b0;
    end else begin
      r_ctx_rd_en     <= (w_state_nxt == S_RD);
      r_ctx_wr_en     <= (w_state_nxt == S_SAVE);
      r_ctx_addr      <= ((w_state_nxt == S_RD) || (w_state_nxt == S_SAVE)) ? w_cur_ch_nxt : '0;
      r_nco_ld        <= (w_state_nxt == S_LD);
      r_nco_fill      <= (w_state_nxt == S_FILL);
      r_nco_down      <= (w_state_nxt == S_RUN);
      r_busy          <= (w_state_nxt != S_IDLE);
      r_round_done    <= w_done_nxt;
      r_round_overrun <= w_overrun_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_nco_code_freq <= '0;
    end else if (r_state == S_LD) begin
      r_nco_code_freq <= ctx_rd_data[71:40];
    end
  end

  // Data paths are gated by their registered strobes so they read zero when idle.
  assign nco_phase_ld      = r_nco_ld ? ctx_rd_data[39:8] : '0;
  assign nco_jump_ld       = r_nco_ld ? ctx_rd_data[7:0]  : '0;
  assign ctx_wr_data       = r_ctx_wr_en ? {nco_phase_cur, nco_jump_cur} : '0;

  assign ctx_rd_en         = r_ctx_rd_en;
  assign ctx_wr_en         = r_ctx_wr_en;
  assign ctx_addr          = r_ctx_addr;
  assign nco_code_freq     = r_nco_code_freq;
  assign nco_phase_en      = r_nco_ld;
  assign nco_jump_en       = r_nco_ld;
  assign nco_fill_finished = r_nco_fill;
  assign nco_data_down_en  = r_nco_down;
  assign cur_ch            = r_cur_ch;
  assign busy              = r_busy;
  assign round_done        = r_round_done;
  assign round_overrun     = r_round_overrun;

endmodule

// File: tb/tb_code_nco_ctx_sched.sv
// Bench for code_nco_ctx_sched: context RAM + NCO models, arithmetic reference of round results.
module tb_code_nco_ctx_sched;

  localparam int CH_NUM = 32;
  localparam int CH_W   = 5;

  logic              clk = 1'b0;
  logic              rst_b;
  logic              round_start, round_abort;
  logic [CH_NUM-1:0] ch_enable;
  logic [7:0]        blk_len;
  logic              ctx_rd_en, ctx_wr_en;
  logic [CH_W-1:0]   ctx_addr;
  logic [71:0]       ctx_rd_data;
  logic [39:0]       ctx_wr_data;
  logic [31:0]       nco_code_freq;
  logic              nco_phase_en, nco_jump_en, nco_fill_finished, nco_data_down_en;
  logic [31:0]       nco_phase_ld, nco_phase_cur;
  logic [7:0]        nco_jump_ld, nco_jump_cur;
  logic [CH_W-1:0]   cur_ch;
  logic              busy, round_done, round_overrun;

  always #5 clk = ~clk;

  code_nco_ctx_sched #(.CH_NUM(CH_NUM), .CH_W(CH_W)) dut (
    .clk(clk), .rst_b(rst_b), .round_start(round_start), .round_abort(round_abort),
    .ch_enable(ch_enable), .blk_len(blk_len), .ctx_rd_en(ctx_rd_en), .ctx_wr_en(ctx_wr_en),
    .ctx_addr(ctx_addr), .ctx_rd_data(ctx_rd_data), .ctx_wr_data(ctx_wr_data),
    .nco_code_freq(nco_code_freq), .nco_phase_en(nco_phase_en), .nco_phase_ld(nco_phase_ld),
    .nco_jump_en(nco_jump_en), .nco_jump_ld(nco_jump_ld), .nco_fill_finished(nco_fill_finished),
    .nco_data_down_en(nco_data_down_en), .nco_phase_cur(nco_phase_cur), .nco_jump_cur(nco_jump_cur),
    .cur_ch(cur_ch), .busy(busy), .round_done(round_done), .round_overrun(round_overrun)
  );

  // Context RAM model with a preload port
  logic [71:0]     ram [CH_NUM];
  logic            ld_en;
  logic [CH_W-1:0] ld_addr;
  logic [71:0]     ld_data;
  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (ctx_wr_en) ram[ctx_addr][39:0] <= ctx_wr_data;
    if (ctx_rd_en) ctx_rd_data <= ram[ctx_addr];
  end

  // NCO model: phase accumulates freq per strobe, each wrap bumps the jump count
  logic [31:0] nco_ph;
  logic [7:0]  nco_jc;
  logic [32:0] nco_sum;
  assign nco_sum       = {1'b0, nco_ph} + {1'b0, nco_code_freq};
  assign nco_phase_cur = nco_ph;
  assign nco_jump_cur  = nco_jc;
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      nco_ph <= '0;
      nco_jc <= '0;
    end else begin
      if (nco_phase_en) nco_ph <= nco_phase_ld;
      else if (nco_data_down_en) nco_ph <= nco_sum[31:0];
      if (nco_jump_en) nco_jc <= nco_jump_ld;
      else if (nco_data_down_en && nco_sum[32]) nco_jc <= nco_jc + 8'd1;
    end
  end

  // Bus monitor
  int              cyc = 0, done_cnt = 0, ovr_cnt = 0, viol = 0, start_cyc = 0, done_cyc = 0;
  bit              prev_busy = 1'b0;
  logic [CH_W-1:0] rd_q[$];
  logic [44:0]     wr_q[$];
  always @(negedge clk) begin
    cyc++;
    if (busy && !prev_busy) start_cyc = cyc;
    prev_busy = busy;
    if (ctx_rd_en) rd_q.push_back(ctx_addr);
    if (ctx_wr_en) wr_q.push_back({ctx_addr, ctx_wr_data});
    if (round_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (round_overrun) ovr_cnt++;
    if ((int'(ctx_rd_en) + int'(ctx_wr_en) + int'(nco_phase_en) + int'(nco_fill_finished)
         + int'(nco_data_down_en)) > 1) viol++;
  end

  int          nvec = 0, nerr = 0;
  logic [71:0] exp_mem [CH_NUM];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel context after len strobes: phase + len*freq, carries added to jump count
  function automatic logic [39:0] upd(input logic [71:0] e, input logic [7:0] len);
    logic [63:0] tot;
    tot = 64'(e[39:8]) + 64'(len) * 64'(e[71:40]);
    return {tot[31:0], 8'(e[7:0] + tot[39:32])};
  endfunction

  task automatic preload(input int a, input logic [71:0] d);
    ld_en = 1'b1; ld_addr = CH_W'(a); ld_data = d;
    tick();
    ld_en = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic run_round(input logic [31:0] mask, input logic [7:0] len, input bit do_ovr);
    int rd_b, wr_b, done_b, ovr_b, viol_b, n, k, ch;
    int exp_ch[$];
    logic [39:0] ev;
    rd_b = rd_q.size(); wr_b = wr_q.size(); done_b = done_cnt; ovr_b = ovr_cnt; viol_b = viol;
    ch_enable = mask; blk_len = len; round_start = 1'b1;
    tick();
    round_start = 1'b0;
    ch_enable = $urandom; blk_len = 8'($urandom);
    if (do_ovr) begin
      n = 0;
      while (!nco_data_down_en && n < 5000) begin tick(); n++; end
      check("ovr_wait_to", 64'(n >= 5000), 0);
      round_start = 1'b1;
      tick();
      round_start = 1'b0;
    end
    n = 0;
    while (done_cnt == done_b && n < 20000) begin tick(); n++; end
    tick(); tick();
    check("done_cnt", 64'(done_cnt - done_b), 1);
    check("ovr_cnt", 64'(ovr_cnt - ovr_b), 64'(do_ovr));
    for (int c = 0; c < CH_NUM; c++) if (mask[c]) exp_ch.push_back(c);
    k = exp_ch.size();
    check("rd_cnt", 64'(rd_q.size() - rd_b), 64'(k));
    check("wr_cnt", 64'(wr_q.size() - wr_b), 64'(k));
    for (int j = 0; j < k; j++) begin
      ch = exp_ch[j];
      ev = upd(exp_mem[ch], len);
      if (rd_b + j < rd_q.size()) check("rd_addr", 64'(rd_q[rd_b + j]), 64'(ch));
      if (wr_b + j < wr_q.size()) begin
        check("wr_addr", 64'(wr_q[wr_b + j][44:40]), 64'(ch));
        check("wr_data", 64'(wr_q[wr_b + j][39:0]), 64'(ev));
      end
      exp_mem[ch][39:0] = ev;
    end
    if (done_cnt > done_b) check("round_len", 64'(done_cyc - start_cyc + 1), 64'(k * (int'(len) + 5) + 1));
    if (k > 0) check("freq_hold", 64'(nco_code_freq), 64'(exp_mem[exp_ch[k-1]][71:40]));
    check("busy_end", 64'(busy), 0);
    check("onehot", 64'(viol - viol_b), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    int n, wr_b, done_b, rd_b;
    rst_b = 1'b0; round_start = 1'b0; round_abort = 1'b0; ch_enable = '0; blk_len = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) tick();
    check("rst_ctl", 64'({ctx_rd_en, ctx_wr_en, ctx_addr, nco_phase_en, nco_jump_en, nco_fill_finished,
                          nco_data_down_en, cur_ch, busy, round_done, round_overrun}), 0);
    check("rst_freq", 64'(nco_code_freq), 0);
    check("rst_ld", 64'({nco_phase_ld, nco_jump_ld}), 0);
    check("rst_wdata", 64'(ctx_wr_data), 0);
    rst_b = 1'b1;
    for (int a = 0; a < CH_NUM; a++) preload(a, {$urandom, $urandom, 8'($urandom)});
    tick();

    // start and abort together in IDLE: both ignored
    round_start = 1'b1; round_abort = 1'b1; ch_enable = '1;
    tick();
    round_start = 1'b0; round_abort = 1'b0;
    check("idle_start_abort", 64'(busy), 0);

    // single channel directed case
    preload(2, {32'h8000_0000, 32'h4000_0000, 8'h00});
    run_round(32'h0000_0004, 8'd3, 1'b0);
    check("tp1_ram2", 64'(ram[2][39:0]), 64'h00_C000_0000_01);

    run_round(32'h8000_0011, 8'd2, 1'b0);
    run_round(32'h0000_0000, 8'd5, 1'b0);
    run_round(32'h0000_0040, 8'd0, 1'b0);

    // abort on 2nd RUN cycle of channel 1
    wr_b = wr_q.size(); done_b = done_cnt;
    ch_enable = 32'h0000_0083; blk_len = 8'd8; round_start = 1'b1;
    tick();
    round_start = 1'b0;
    n = 0;
    while (!(cur_ch == CH_W'(1) && nco_data_down_en) && n < 2000) begin tick(); n++; end
    check("abort_wait_to", 64'(n >= 2000), 0);
    tick();
    round_abort = 1'b1;
    tick();
    round_abort = 1'b0;
    check("abort_busy", 64'(busy), 0);
    check("abort_wren", 64'(ctx_wr_en), 0);
    repeat (4) tick();
    check("abort_wrcnt", 64'(wr_q.size() - wr_b), 1);
    if (wr_q.size() > wr_b) check("abort_w0", 64'(wr_q[wr_b][39:0]), 64'(upd(exp_mem[0], 8'd8)));
    exp_mem[0][39:0] = upd(exp_mem[0], 8'd8);
    check("abort_done", 64'(done_cnt - done_b), 0);
    run_round(32'h0000_0003, 8'd2, 1'b0);

    // overrun during RUN
    run_round(32'h0000_0106, 8'd5, 1'b1);

    // start + abort together while busy: abort wins, no new round
    wr_b = wr_q.size(); done_b = done_cnt;
    ch_enable = 32'h0000_0009; blk_len = 8'd4; round_start = 1'b1;
    tick();
    round_start = 1'b0;
    tick();
    round_start = 1'b1; round_abort = 1'b1;
    tick();
    round_start = 1'b0; round_abort = 1'b0;
    check("sa_busy", 64'(busy), 0);
    repeat (5) tick();
    check("sa_busy_hold", 64'(busy), 0);
    check("sa_wrcnt", 64'(wr_q.size() - wr_b), 0);
    check("sa_done", 64'(done_cnt - done_b), 0);

    // randomized rounds
    for (int r = 0; r < 8; r++) begin
      run_round($urandom & $urandom, 8'($urandom_range(0, 12)), 1'b0);
    end

    // async reset in the middle of a SAVE cycle
    ch_enable = 32'h0000_0500; blk_len = 8'd3; round_start = 1'b1;
    tick();
    round_start = 1'b0;
    n = 0;
    while (!ctx_wr_en && n < 2000) begin tick(); n++; end
    check("save_wait_to", 64'(n >= 2000), 0);
    #2 rst_b = 1'b0;
    #1;
    check("mrst_ctl", 64'({ctx_rd_en, ctx_wr_en, ctx_addr, nco_phase_en, nco_jump_en, nco_fill_finished,
                           nco_data_down_en, cur_ch, busy, round_done, round_overrun}), 0);
    check("mrst_freq", 64'(nco_code_freq), 0);
    check("mrst_wdata", 64'(ctx_wr_data), 0);
    tick(); tick();
    rst_b = 1'b1;
    wr_b = wr_q.size(); rd_b = rd_q.size();
    repeat (6) tick();
    check("mrst_busy", 64'(busy), 0);
    check("mrst_wrcnt", 64'(wr_q.size() - wr_b), 0);
    check("mrst_rdcnt", 64'(rd_q.size() - rd_b), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/code_nco_ctx_sched.md
Name: code_nco_ctx_sched

Overview:
- Time-multiplexes one code NCO overflow generator across CH_NUM tracking channels.
- Each round visits every enabled channel in ascending index order. Per channel it:
  - reads the saved context (code_freq, code_phase, jump_count) from the context RAM;
  - loads the context into the NCO;
  - runs blk_len sample strobes;
  - writes the updated phase and jump count back.
- Sits between the correlator round trigger, the channel context RAM and the overflow generator.

Parameters:
- CH_NUM, 32, number of channel contexts.
- CH_W, 5, channel index width; equals log2(CH_NUM).

Ports:
- clk  in  1  system clock
- rst_b  in  1  asynchronous active-low reset
- round_start  in  1  single-cycle pulse; starts a round
- round_abort  in  1  single-cycle pulse; aborts the current round
- ch_enable  in  CH_NUM  channel active mask; captured at an accepted round_start
- blk_len  in  8  sample strobes per channel; captured at an accepted round_start
- ctx_rd_en  out  1  context RAM read strobe
- ctx_wr_en  out  1  context RAM write strobe
- ctx_addr  out  CH_W  context RAM address (shared by read and write)
- ctx_rd_data  in  72  {code_freq[71:40], code_phase[39:8], jump_count[7:0]}; valid 1 cycle after ctx_rd_en
- ctx_wr_data  out  40  {code_phase[39:8], jump_count[7:0]}
- nco_code_freq  out  32  frequency word driven to the NCO; registered
- nco_phase_en  out  1  NCO phase load strobe
- nco_phase_ld  out  32  phase value to load
- nco_jump_en  out  1  NCO jump count load strobe
- nco_jump_ld  out  8  jump count value to load
- nco_fill_finished  out  1  commits the loaded jump count inside the NCO
- nco_data_down_en  out  1  sample strobe to the NCO
- nco_phase_cur  in  32  current NCO phase
- nco_jump_cur  in  8  current NCO jump count
- cur_ch  out  CH_W  channel currently being processed
- busy  out  1  high in every state except IDLE
- round_done  out  1  one-cycle pulse when a round completes normally
- round_overrun  out  1  one-cycle pulse when round_start arrives while busy

Behaviour:
- Reset: all outputs are 0; FSM is in IDLE; pending mask is 0.
- States: IDLE, SCAN, RD, LD, FILL, RUN, SAVE.
- IDLE:
  - round_start → SCAN.
  - Capture pending = ch_enable, blk_len_r = blk_len, cur_ch = 0.
- SCAN:
  - Select the lowest set bit of pending, combinational priority encode in one cycle.
  - If none is set: pulse round_done, go to IDLE.
  - Otherwise: cur_ch = that index, clear the bit in pending, go to RD.
- RD: ctx_rd_en = 1, ctx_addr = cur_ch → LD.
- LD (ctx_rd_data valid):
  - nco_phase_en = 1 and nco_jump_en = 1.
  - nco_phase_ld and nco_jump_ld are taken from ctx_rd_data.
  - nco_code_freq register loads ctx_rd_data[71:40].
  - Next state: FILL.
- FILL: nco_fill_finished = 1.
  - Next state: RUN, with sample counter = blk_len_r.
  - If blk_len_r == 0, go directly to SAVE.
- RUN:
  - nco_data_down_en = 1 each cycle; counter decrements.
  - Leave for SAVE in the cycle the counter reads 1.
  - RUN therefore lasts exactly blk_len_r cycles.
- SAVE:
  - ctx_wr_en = 1, ctx_addr = cur_ch.
  - ctx_wr_data = {nco_phase_cur, nco_jump_cur}, sampled in the SAVE cycle.
  - Next state: SCAN.
- Per-channel cost is blk_len+5 cycles. A round with k enabled channels lasts k*(blk_len+5)+1 cycles, counted from the first SCAN up to and including the round_done cycle.
- nco_code_freq holds its last value between channels and after the round ends.
- Strobes are decoded from state and are glitch-free registered-state outputs. At most one of ctx_rd_en, ctx_wr_en, nco_phase_en, nco_fill_finished, nco_data_down_en is high in any cycle.
- round_start while busy: ignored, and round_overrun pulses. pending and blk_len_r are unchanged.
- round_abort in any non-IDLE state:
  - Next state is IDLE, pending is cleared, and no write-back occurs (an aborted channel's context is not updated).
  - round_done is not pulsed.
  - If round_abort arrives in the SAVE cycle, that cycle's write still completes.
- round_abort and round_start in the same cycle: abort wins. If in IDLE, both are ignored.
- ch_enable == 0 at start: SCAN → round_done on the cycle after round_start.
- Changes to ch_enable or blk_len during a round have no effect.
- Highest channel (CH_NUM-1) is reachable; cur_ch does not wrap within a round.

Test Plan:
- Single channel: ch_enable = 0x00000004, blk_len = 3; RAM[2] = {freq 0x80000000, phase 0x40000000, jump 0}.
  - Expect RD at addr 2, then LD, FILL, three data_down_en, then write addr 2 with phase 0xC0000000 and the NCO's jump value.
  - round_done asserts 9 cycles after SCAN begins.
- Multi-channel order: ch_enable = 0x80000011, blk_len = 2.
  - Channels are visited 0, 4, 31 in that order.
  - 3 writes occur; round_done exactly 3*7+1 = 22 cycles after the first SCAN.
- Empty and zero-length:
  - ch_enable = 0 → round_done one cycle after the IDLE→SCAN transition, with no RAM access.
  - blk_len = 0 with one channel → FILL goes directly to SAVE; written phase equals the read phase.
- Abort in RUN: abort on the 2nd RUN cycle of channel 1 (blk_len = 8).
  - Expect IDLE next cycle, no ctx_wr_en, no round_done, busy = 0.
  - A new round then restarts from channel 0.
- Overrun:
  - round_start during RUN → round_overrun pulse; the current round completes unchanged with a single round_done.
  - Simultaneous start and abort while busy → abort taken.
- Async reset asserted mid-SAVE → all outputs 0 immediately; after release, state is IDLE and ctx_wr_en stays 0.
